// File: rtl/req_arbiter.sv
// req_arbiter: 4-requester arbiter with a held one-hot grant, a hold-limit
// counter that preempts long owners, and a guaranteed one-cycle dead gap
// between owners. Default priority is fixed, highest index wins.
// Optional feature: define REQ_ARBITER_ROUND_ROBIN_EN to rotate priority so
// the most recent winner becomes the lowest-priority requester.
module req_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic [1:0]    win_id;

`ifdef REQ_ARBITER_ROUND_ROBIN_EN
    logic [1:0] last_id;
    logic [1:0] idx;

    // Rotating search: scan from lowest to highest priority so the last hit
    // (last_id-1, descending with wrap) is the winner.
    always_comb begin
        win_id = '0;
        idx    = '0;
        for (int unsigned i = 4; i >= 1; i--) begin
            idx = last_id - 2'(i);
            if (req[idx]) begin
                win_id = idx;
            end
        end
    end
`else
    // Fixed priority: ascending scan, so the highest set index wins.
    always_comb begin
        win_id = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (req[i]) begin
                win_id = 2'(i);
            end
        end
    end
`endif

    // Arbitration FSM with registered grant, index, valid and timeout outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
            last_id   <= '0;
`endif
        end else begin
            case (state)
                IDLE, GAP: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        state     <= GRANT;
                        gnt       <= 4'b0001 << win_id;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
                        last_id   <= win_id;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[gnt_id] || hold_cnt == HOLD_LAST) begin
                        // Release takes precedence: timeout only when the owner still requests.
                        state     <= GAP;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                        timeout   <= req[gnt_id];
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    timeout   <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed testbench for req_arbiter with MAX_HOLD=4.
module tb_req_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int nchk;
    int nerr;

    req_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] outs();
        return {24'b0, timeout, gnt_valid, gnt_id, gnt};
    endfunction

    function automatic logic [31:0] ev(logic [3:0] g, logic [1:0] id, logic v, logic t);
        return {24'b0, t, v, id, g};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_ids [5];

    initial begin
        nchk = 0;
        nerr = 0;
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
        exp_ids = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
        exp_ids = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        check("reset_state", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
        rst = 1'b0;

        // Idle: nothing happens for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
        end

        // All requesting: each owner held 4 cycles then preempted
        req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                check("all_req_grant", outs(), ev(4'b0001 << exp_ids[o], exp_ids[o], 1'b1, 1'b0));
            end
            tick();
            check("all_req_gap_timeout", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b1));
        end
        req = 4'b0000;
        tick();
        check("all_req_to_idle", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b0));

        // Fixed priority among 1 and 2, gap with pending request
        req = 4'b0110;
        tick();
        check("prio_grant2", outs(), ev(4'b0100, 2'd2, 1'b1, 1'b0));
        req = 4'b0010;
        tick();
        check("prio_gap", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        check("prio_grant1", outs(), ev(4'b0010, 2'd1, 1'b1, 1'b0));
        req = 4'b0000;
        tick();
        check("prio_release_gap", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        check("prio_idle", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b0));

        // Hold limit: requester 0 held continuously
        req = 4'b0001;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                check("hold_grant", outs(), ev(4'b0001, 2'd0, 1'b1, 1'b0));
            end
            tick();
            check("hold_timeout_gap", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b1));
        end

        // Release in the 4th grant cycle beats the timeout
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rel_grant", outs(), ev(4'b0001, 2'd0, 1'b1, 1'b0));
        end
        req = 4'b0000;
        tick();
        check("rel_beats_timeout", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
        tick();
        check("rel_idle", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b0));

        // Asynchronous reset mid-grant
        req = 4'b1000;
        tick();
        check("pre_reset_grant", outs(), ev(4'b1000, 2'd3, 1'b1, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_drop", outs(), ev(4'b0000, 2'd0, 1'b0, 1'b0));
        rst = 1'b0;
        tick();
        check("post_reset_grant", outs(), ev(4'b1000, 2'd3, 1'b1, 1'b0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
